// File: rtl/vend_pkg.sv
// rtl/vend_pkg.sv - shared types, error codes and selector helpers for vending_machine_gen
package vend_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CREDIT,
        ST_CHECK,
        ST_VEND,
        ST_REFUND
    } state_t;

    localparam logic [2:0] ERR_NONE    = 3'd0;
    localparam logic [2:0] ERR_INVALID = 3'd1;
    localparam logic [2:0] ERR_FUNDS   = 3'd2;
    localparam logic [2:0] ERR_SOLDOUT = 3'd3;
    localparam logic [2:0] ERR_TIMEOUT = 3'd4;
    localparam logic [2:0] ERR_CANCEL  = 3'd5;

    // Selector fields are zero-extended to 32 bits, so up to 32 rows/columns are supported
    function automatic logic is_onehot(input logic [31:0] v);
        return $onehot(v);
    endfunction

    function automatic logic [4:0] onehot_index(input logic [31:0] v);
        logic [4:0] idx;
        idx = '0;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) idx = 5'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/vending_machine_gen_if.sv
// rtl/vending_machine_gen_if.sv - front-end / actuator signal bundle for vending_machine_gen
interface vending_machine_gen_if #(
    parameter int MONEY_W = 16,
    parameter int N_ROWS  = 4,
    parameter int N_COLS  = 4,
    parameter int SEL_W   = $clog2(N_ROWS * N_COLS)
);
    logic               coin_valid;
    logic [MONEY_W-1:0] coin_value;
    logic [N_ROWS-1:0]  row_sel;
    logic [N_COLS-1:0]  col_sel;
    logic               select_strobe;
    logic               cancel;
    logic               price_wr_en;
    logic [SEL_W-1:0]   price_wr_addr;
    logic [MONEY_W-1:0] price_wr_data;
    logic               restock;
    logic [MONEY_W-1:0] credit;
    logic [MONEY_W-1:0] price;
    logic [SEL_W-1:0]   selection;
    logic               success;
    logic [MONEY_W-1:0] change;
    logic               change_valid;
    logic               coin_reject;
    logic [2:0]         error;
    logic               busy;

    modport master (
        output coin_valid, coin_value, row_sel, col_sel, select_strobe, cancel,
               price_wr_en, price_wr_addr, price_wr_data, restock,
        input  credit, price, selection, success, change, change_valid,
               coin_reject, error, busy
    );

    modport slave (
        input  coin_valid, coin_value, row_sel, col_sel, select_strobe, cancel,
               price_wr_en, price_wr_addr, price_wr_data, restock,
        output credit, price, selection, success, change, change_valid,
               coin_reject, error, busy
    );
endinterface

// File: rtl/vend_timeout_timer.sv
// rtl/vend_timeout_timer.sv - inactivity counter that flags the last idle cycle before refund
module vend_timeout_timer #(
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic clk,
    input  logic reset,
    input  logic enable,
    input  logic clear,
    output logic expire
);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    logic [CNT_W-1:0] count_q, count_d;

    // Count only while enabled; leaving the enabled state or any activity restarts from zero
    always_comb begin
        count_d = count_q + CNT_W'(1);
        if (!enable || clear) count_d = '0;
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign expire = enable && (count_q == CNT_W'(TIMEOUT_CYC - 1));

endmodule

// File: rtl/vending_machine_gen.sv
// rtl/vending_machine_gen.sv - parametrised vending controller with price table, stock and refund paths
module vending_machine_gen
    import vend_pkg::*;
#(
    parameter int MONEY_W     = 16,
    parameter int N_ROWS      = 4,
    parameter int N_COLS      = 4,
    parameter int STOCK_W     = 4,
    parameter int INIT_STOCK  = 8,
    parameter int PRICE_BASE  = 25,
    parameter int MAX_CREDIT  = 1000,
    parameter int TIMEOUT_CYC = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    vending_machine_gen_if.slave  bus
);
    localparam int N_SLOTS = N_ROWS * N_COLS;
    localparam int SEL_W   = $clog2(N_SLOTS);

    state_t             state_q, state_d;
    logic [MONEY_W-1:0] credit_q, credit_d;
    logic [MONEY_W-1:0] price_q, price_d;
    logic [MONEY_W-1:0] change_q, change_d;
    logic [SEL_W-1:0]   selection_q, selection_d;
    logic               success_q, success_d;
    logic               change_valid_q, change_valid_d;
    logic               coin_reject_q, coin_reject_d;
    logic               busy_q, busy_d;
    logic [2:0]         error_q, error_d;
    logic [N_ROWS-1:0]  row_q, row_d;
    logic [N_COLS-1:0]  col_q, col_d;
    logic [STOCK_W-1:0] stock_q [N_SLOTS];
    logic [STOCK_W-1:0] stock_d [N_SLOTS];
    logic [MONEY_W-1:0] price_tbl_q [N_SLOTS];
    logic [MONEY_W-1:0] price_tbl_d [N_SLOTS];

    logic [MONEY_W:0]   coin_sum;
    logic               coin_fits, coin_take, in_entry;
    logic               timer_en, timer_clr, timer_expire;
    logic               sel_ok;
    logic [SEL_W-1:0]   sel_idx;

    // One extra bit so the ceiling compare cannot wrap
    assign coin_sum  = {1'b0, credit_q} + {1'b0, bus.coin_value};
    assign coin_fits = coin_sum <= (MONEY_W + 1)'(MAX_CREDIT);
    assign in_entry  = (state_q == ST_IDLE) || (state_q == ST_CREDIT);
    assign coin_take = bus.coin_valid && in_entry && coin_fits;

    assign timer_en  = (state_q == ST_CREDIT);
    assign timer_clr = coin_take || bus.select_strobe || bus.cancel;

    assign sel_ok  = is_onehot(32'(row_q)) && is_onehot(32'(col_q));
    assign sel_idx = SEL_W'(32'(onehot_index(32'(row_q))) * N_COLS
                          + 32'(onehot_index(32'(col_q))));

    vend_timeout_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .enable (timer_en),
        .clear  (timer_clr),
        .expire (timer_expire)
    );

    // Next-state and next-output logic for the transaction FSM
    always_comb begin
        state_d        = state_q;
        credit_d       = credit_q;
        price_d        = price_q;
        change_d       = change_q;
        selection_d    = selection_q;
        error_d        = error_q;
        row_d          = row_q;
        col_d          = col_q;
        success_d      = 1'b0;
        change_valid_d = 1'b0;
        coin_reject_d  = 1'b0;
        stock_d        = stock_q;
        price_tbl_d    = price_tbl_q;

        if (bus.coin_valid) begin
            if (coin_take) begin
                credit_d = coin_sum[MONEY_W-1:0];
                error_d  = ERR_NONE;
            end else begin
                coin_reject_d = 1'b1;
            end
        end

        case (state_q)
            ST_IDLE: begin
                if (coin_take)         state_d = ST_CREDIT;
                if (bus.select_strobe) error_d = ERR_FUNDS;
                if (bus.price_wr_en)   price_tbl_d[bus.price_wr_addr] = bus.price_wr_data;
                if (bus.restock) begin
                    for (int i = 0; i < N_SLOTS; i++) stock_d[i] = STOCK_W'(INIT_STOCK);
                end
            end
            ST_CREDIT: begin
                if (bus.cancel) begin
                    state_d = ST_REFUND;
                    error_d = ERR_CANCEL;
                end else if (bus.select_strobe) begin
                    row_d   = bus.row_sel;
                    col_d   = bus.col_sel;
                    state_d = ST_CHECK;
                end else if (timer_expire && !coin_take) begin
                    state_d = ST_REFUND;
                    error_d = ERR_TIMEOUT;
                end
            end
            ST_CHECK: begin
                if (!sel_ok) begin
                    error_d = ERR_INVALID;
                    state_d = ST_CREDIT;
                end else begin
                    price_d     = price_tbl_q[sel_idx];
                    selection_d = sel_idx;
                    if (stock_q[sel_idx] == '0) begin
                        error_d = ERR_SOLDOUT;
                        state_d = ST_CREDIT;
                    end else if (credit_q < price_tbl_q[sel_idx]) begin
                        error_d = ERR_FUNDS;
                        state_d = ST_CREDIT;
                    end else begin
                        state_d = ST_VEND;
                    end
                end
            end
            ST_VEND: begin
                success_d              = 1'b1;
                change_d               = credit_q - price_q;
                change_valid_d         = 1'b1;
                credit_d               = '0;
                stock_d[selection_q]   = stock_q[selection_q] - STOCK_W'(1);
                error_d                = ERR_NONE;
                state_d                = ST_IDLE;
            end
            ST_REFUND: begin
                change_d       = credit_q;
                change_valid_d = 1'b1;
                credit_d       = '0;
                state_d        = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        busy_d = (state_d == ST_CHECK) || (state_d == ST_VEND) || (state_d == ST_REFUND);
    end

    // State, registered outputs, stock counters and price table
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q        <= ST_IDLE;
            credit_q       <= '0;
            price_q        <= '0;
            change_q       <= '0;
            selection_q    <= '0;
            error_q        <= ERR_NONE;
            row_q          <= '0;
            col_q          <= '0;
            success_q      <= 1'b0;
            change_valid_q <= 1'b0;
            coin_reject_q  <= 1'b0;
            busy_q         <= 1'b0;
            for (int i = 0; i < N_SLOTS; i++) begin
                stock_q[i]     <= STOCK_W'(INIT_STOCK);
                price_tbl_q[i] <= MONEY_W'(PRICE_BASE * (i + 1));
            end
        end else begin
            state_q        <= state_d;
            credit_q       <= credit_d;
            price_q        <= price_d;
            change_q       <= change_d;
            selection_q    <= selection_d;
            error_q        <= error_d;
            row_q          <= row_d;
            col_q          <= col_d;
            success_q      <= success_d;
            change_valid_q <= change_valid_d;
            coin_reject_q  <= coin_reject_d;
            busy_q         <= busy_d;
            stock_q        <= stock_d;
            price_tbl_q    <= price_tbl_d;
        end
    end

    assign bus.credit       = credit_q;
    assign bus.price        = price_q;
    assign bus.selection    = selection_q;
    assign bus.success      = success_q;
    assign bus.change       = change_q;
    assign bus.change_valid = change_valid_q;
    assign bus.coin_reject  = coin_reject_q;
    assign bus.error        = error_q;
    assign bus.busy         = busy_q;

endmodule
